// File: rtl/axi_mem_req_master.sv
// Single-outstanding INCR AXI burst master; R and W data pass through combinationally with zero latency.
// Backpressure: req_rdy is high only in IDLE; rsp_rdy drives rready_m0 and wready_m0 drives wd_rdy directly.
module axi_mem_req_master #(
    parameter int         DW   = 128,
    parameter int         STRB = DW/8,
    parameter int         AW   = 32,
    parameter logic [7:0] ID   = 8'h5A,
    parameter int         TO_W = 10
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_wr,
    input  logic [AW-1:0]     req_addr,
    input  logic [7:0]        req_len,
    input  logic              wd_vld,
    output logic              wd_rdy,
    input  logic [DW-1:0]     wd_data,
    input  logic [STRB-1:0]   wd_strb,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_last,
    output logic              wr_done,
    output logic              err_sticky,
    output logic [1:0]        err_code,
    output logic [AW-1:0]     araddr_m0,
    output logic [1:0]        arburst_m0,
    output logic [3:0]        arcache_m0,
    output logic [7:0]        arid_m0,
    output logic [7:0]        arlen_m0,
    output logic [2:0]        arprot_m0,
    output logic [2:0]        arsize_m0,
    output logic              arvalid_m0,
    input  logic              arready_m0,
    output logic [AW-1:0]     awaddr_m0,
    output logic [1:0]        awburst_m0,
    output logic [3:0]        awcache_m0,
    output logic [7:0]        awid_m0,
    output logic [7:0]        awlen_m0,
    output logic [2:0]        awprot_m0,
    output logic [2:0]        awsize_m0,
    output logic              awvalid_m0,
    input  logic              awready_m0,
    output logic [DW-1:0]     wdata_m0,
    output logic [7:0]        wid_m0,
    output logic              wlast_m0,
    output logic [STRB-1:0]   wstrb_m0,
    output logic              wvalid_m0,
    input  logic              wready_m0,
    input  logic [DW-1:0]     rdata_m0,
    input  logic [7:0]        rid_m0,
    input  logic              rlast_m0,
    input  logic [1:0]        rresp_m0,
    input  logic              rvalid_m0,
    output logic              rready_m0,
    input  logic [7:0]        bid_m0,
    input  logic [1:0]        bresp_m0,
    input  logic              bvalid_m0,
    output logic              bready_m0
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_AW, S_R, S_W, S_B} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-5:0]     addr_q;
    logic [7:0]        len_q;
    logic [7:0]        cnt;
    logic [TO_W-1:0]   wdog;
    logic              wdog_to;
    logic              last_beat;
    logic              ar_hs, aw_hs, w_hs, r_hs, b_hs, any_hs;
    logic              err_set;
    logic [1:0]        err_new;
    logic              unused_in;

    // IDs are constant and only one burst is ever outstanding, so returned IDs carry no information.
    assign unused_in = ^{rid_m0, bid_m0, req_addr[3:0]};

    assign last_beat = (cnt == len_q);
    assign ar_hs     = arvalid_m0 & arready_m0;
    assign aw_hs     = awvalid_m0 & awready_m0;
    assign w_hs      = wvalid_m0 & wready_m0;
    assign r_hs      = rvalid_m0 & rready_m0;
    assign b_hs      = bvalid_m0 & bready_m0;
    assign any_hs    = ar_hs | aw_hs | w_hs | r_hs | b_hs;
    assign wdog_to   = &wdog;

    assign araddr_m0  = {addr_q, 4'h0};
    assign arburst_m0 = 2'b01;
    assign arcache_m0 = 4'b0011;
    assign arid_m0    = ID;
    assign arlen_m0   = len_q;
    assign arprot_m0  = 3'b000;
    assign arsize_m0  = 3'b100;
    assign awaddr_m0  = {addr_q, 4'h0};
    assign awburst_m0 = 2'b01;
    assign awcache_m0 = 4'b0011;
    assign awid_m0    = ID;
    assign awlen_m0   = len_q;
    assign awprot_m0  = 3'b000;
    assign awsize_m0  = 3'b100;
    assign wid_m0     = ID;
    assign wdata_m0   = wd_data;
    assign wstrb_m0   = wd_strb;
    assign rsp_data   = rdata_m0;

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_vld)             state_nxt = req_wr ? S_AW : S_AR;
            S_AR:   if (arready_m0)          state_nxt = S_R;
            S_AW:   if (awready_m0)          state_nxt = S_W;
            S_R:    if (r_hs && last_beat)   state_nxt = S_IDLE;
            S_W:    if (w_hs && last_beat)   state_nxt = S_B;
            S_B:    if (bvalid_m0)           state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_rdy    = 1'b0;
        arvalid_m0 = 1'b0;
        awvalid_m0 = 1'b0;
        rready_m0  = 1'b0;
        rsp_vld    = 1'b0;
        rsp_last   = 1'b0;
        wvalid_m0  = 1'b0;
        wd_rdy     = 1'b0;
        wlast_m0   = 1'b0;
        bready_m0  = 1'b0;
        wr_done    = 1'b0;
        case (state)
            S_IDLE: req_rdy    = 1'b1;
            S_AR:   arvalid_m0 = 1'b1;
            S_AW:   awvalid_m0 = 1'b1;
            S_R: begin
                rready_m0 = rsp_rdy;
                rsp_vld   = rvalid_m0;
                rsp_last  = rvalid_m0 & last_beat;
            end
            S_W: begin
                wvalid_m0 = wd_vld;
                wd_rdy    = wready_m0;
                wlast_m0  = last_beat;
            end
            S_B: begin
                bready_m0 = 1'b1;
                wr_done   = bvalid_m0;
            end
            default: req_rdy = 1'b0;
        endcase
    end

    // Response errors outrank framing errors, which outrank the watchdog, when they coincide.
    always_comb begin
        err_set = 1'b0;
        err_new = 2'b00;
        if ((r_hs && rresp_m0 != 2'b00) || (b_hs && bresp_m0 != 2'b00)) begin
            err_set = 1'b1;
            err_new = 2'b01;
        end else if (r_hs && (rlast_m0 != last_beat)) begin
            err_set = 1'b1;
            err_new = 2'b10;
        end else if (wdog_to) begin
            err_set = 1'b1;
            err_new = 2'b11;
        end
    end

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            addr_q     <= '0;
            len_q      <= '0;
            cnt        <= '0;
            wdog       <= '0;
            err_sticky <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            if (state == S_IDLE && req_vld) begin
                addr_q <= req_addr[AW-1:4];
                len_q  <= req_len;
            end
            if (state == S_IDLE) begin
                cnt <= '0;
            end else if (r_hs || w_hs) begin
                cnt <= cnt + 8'd1;
            end
            if (state == S_IDLE || any_hs) begin
                wdog <= '0;
            end else if (!wdog_to) begin
                wdog <= wdog + 1'b1;
            end
            if (err_set && !err_sticky) begin
                err_sticky <= 1'b1;
                err_code   <= err_new;
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_req_master.sv
// Scoreboard bench for axi_mem_req_master: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_axi_mem_req_master;
    localparam int DW = 128, STRB = 16, AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic req_vld, req_rdy, req_wr;
    logic [AW-1:0] req_addr;
    logic [7:0] req_len;
    logic wd_vld, wd_rdy;
    logic [DW-1:0] wd_data;
    logic [STRB-1:0] wd_strb;
    logic rsp_vld, rsp_rdy, rsp_last, wr_done, err_sticky;
    logic [DW-1:0] rsp_data;
    logic [1:0] err_code;
    logic [AW-1:0] araddr_m0, awaddr_m0;
    logic [1:0] arburst_m0, awburst_m0;
    logic [3:0] arcache_m0, awcache_m0;
    logic [7:0] arid_m0, arlen_m0, awid_m0, awlen_m0, wid_m0, rid_m0, bid_m0;
    logic [2:0] arprot_m0, arsize_m0, awprot_m0, awsize_m0;
    logic arvalid_m0, arready_m0, awvalid_m0, awready_m0;
    logic [DW-1:0] wdata_m0, rdata_m0;
    logic [STRB-1:0] wstrb_m0;
    logic wlast_m0, wvalid_m0, wready_m0;
    logic rlast_m0, rvalid_m0, rready_m0;
    logic [1:0] rresp_m0, bresp_m0;
    logic bvalid_m0, bready_m0;

    typedef struct {
        logic [DW-1:0]   d;
        logic [STRB-1:0] s;
        logic            l;
    } beat_t;

    beat_t exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    axi_mem_req_master dut (
        .pll_core_cpuclk(clk), .pad_cpu_rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
        .wd_vld(wd_vld), .wd_rdy(wd_rdy), .wd_data(wd_data), .wd_strb(wd_strb),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .wr_done(wr_done), .err_sticky(err_sticky), .err_code(err_code),
        .araddr_m0(araddr_m0), .arburst_m0(arburst_m0), .arcache_m0(arcache_m0), .arid_m0(arid_m0),
        .arlen_m0(arlen_m0), .arprot_m0(arprot_m0), .arsize_m0(arsize_m0), .arvalid_m0(arvalid_m0),
        .arready_m0(arready_m0),
        .awaddr_m0(awaddr_m0), .awburst_m0(awburst_m0), .awcache_m0(awcache_m0), .awid_m0(awid_m0),
        .awlen_m0(awlen_m0), .awprot_m0(awprot_m0), .awsize_m0(awsize_m0), .awvalid_m0(awvalid_m0),
        .awready_m0(awready_m0),
        .wdata_m0(wdata_m0), .wid_m0(wid_m0), .wlast_m0(wlast_m0), .wstrb_m0(wstrb_m0),
        .wvalid_m0(wvalid_m0), .wready_m0(wready_m0),
        .rdata_m0(rdata_m0), .rid_m0(rid_m0), .rlast_m0(rlast_m0), .rresp_m0(rresp_m0),
        .rvalid_m0(rvalid_m0), .rready_m0(rready_m0),
        .bid_m0(bid_m0), .bresp_m0(bresp_m0), .bvalid_m0(bvalid_m0), .bready_m0(bready_m0)
    );

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_inputs();
        req_vld = 0; req_wr = 0; req_addr = '0; req_len = '0;
        wd_vld = 0; wd_data = '0; wd_strb = '0; rsp_rdy = 0;
        arready_m0 = 0; awready_m0 = 0; wready_m0 = 0;
        rdata_m0 = '0; rid_m0 = 8'h5A; rlast_m0 = 0; rresp_m0 = 0; rvalid_m0 = 0;
        bid_m0 = 8'h5A; bresp_m0 = 0; bvalid_m0 = 0;
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk); #1;
        rst = 1; clear_inputs();
        repeat (n) @(posedge clk);
        #1 rst = 0;
        exp_q.delete();
    endtask

    // Presents one request for one cycle; returns 1ns after the edge that accepted it.
    task automatic issue_req(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len);
        @(posedge clk); #1;
        req_vld = 1; req_wr = wr; req_addr = addr; req_len = len;
        @(posedge clk); #1;
        req_vld = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        n_vec++; if (arvalid_m0 !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid got=%b want=0", arvalid_m0); end
        n_vec++; if (awvalid_m0 !== 1'b0) begin n_bad++; $display("FAIL rst_awvalid got=%b want=0", awvalid_m0); end
        n_vec++; if (wvalid_m0 !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid got=%b want=0", wvalid_m0); end
        n_vec++; if (rready_m0 !== 1'b0) begin n_bad++; $display("FAIL rst_rready got=%b want=0", rready_m0); end
        n_vec++; if (bready_m0 !== 1'b0) begin n_bad++; $display("FAIL rst_bready got=%b want=0", bready_m0); end
        n_vec++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_req_rdy got=%b want=1", req_rdy); end
        n_vec++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL rst_err_sticky got=%b want=0", err_sticky); end
        n_vec++; if (err_code !== 2'b00) begin n_bad++; $display("FAIL rst_err_code got=%b want=00", err_code); end
        n_vec++; if (wr_done !== 1'b0) begin n_bad++; $display("FAIL rst_wr_done got=%b want=0", wr_done); end
    endtask

    task automatic test_read_single();
        beat_t e;
        issue_req(1'b0, 32'h0000_101C, 8'd0);
        @(negedge clk);
        n_vec++; if (arvalid_m0 !== 1'b1) begin n_bad++; $display("FAIL rd1_arvalid got=%b want=1", arvalid_m0); end
        n_vec++; if (awvalid_m0 !== 1'b0) begin n_bad++; $display("FAIL rd1_awvalid got=%b want=0", awvalid_m0); end
        n_vec++; if (req_rdy !== 1'b0) begin n_bad++; $display("FAIL rd1_req_rdy got=%b want=0", req_rdy); end
        n_vec++; if (araddr_m0 !== 32'h0000_1010) begin n_bad++; $display("FAIL rd1_araddr got=%h want=00001010", araddr_m0); end
        n_vec++; if (arlen_m0 !== 8'd0) begin n_bad++; $display("FAIL rd1_arlen got=%h want=00", arlen_m0); end
        n_vec++; if ({arburst_m0, arsize_m0, arcache_m0, arprot_m0} !== {2'b01, 3'b100, 4'b0011, 3'b000})
            begin n_bad++; $display("FAIL rd1_arattr got=%b/%b/%b/%b want=01/100/0011/000", arburst_m0, arsize_m0, arcache_m0, arprot_m0); end
        n_vec++; if (arid_m0 !== 8'h5A) begin n_bad++; $display("FAIL rd1_arid got=%h want=5a", arid_m0); end
        @(posedge clk); #1 arready_m0 = 1;
        @(negedge clk);
        n_vec++; if (arvalid_m0 !== 1'b1) begin n_bad++; $display("FAIL rd1_arvalid_hold got=%b want=1", arvalid_m0); end
        @(posedge clk); #1;
        arready_m0 = 0; rsp_rdy = 1;
        rdata_m0 = rand128(); rvalid_m0 = 1; rlast_m0 = 1; rresp_m0 = 0;
        exp_q.push_back('{rdata_m0, '0, 1'b1});
        @(negedge clk);
        n_vec++;
        if (rsp_vld && rready_m0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rsp_data !== e.d) begin n_bad++; $display("FAIL rd1_data got=%h want=%h", rsp_data, e.d); end
            n_vec++; if (rsp_last !== e.l) begin n_bad++; $display("FAIL rd1_last got=%b want=%b", rsp_last, e.l); end
        end else begin
            n_bad++; $display("FAIL rd1_beat got vld=%b rready=%b want 1/1", rsp_vld, rready_m0);
        end
        @(posedge clk); #1 rvalid_m0 = 0; rlast_m0 = 0;
        @(negedge clk);
        n_vec++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL rd1_idle got=%b want=1", req_rdy); end
        n_vec++; if (rsp_vld !== 1'b0) begin n_bad++; $display("FAIL rd1_rsp_vld_end got=%b want=0", rsp_vld); end
        exp_q.delete();
    endtask

    task automatic test_write_gaps();
        beat_t e;
        int beats, pushed;
        beats = 0; pushed = 0;
        issue_req(1'b1, 32'h0000_2008, 8'd3);
        @(negedge clk);
        n_vec++; if (awvalid_m0 !== 1'b1) begin n_bad++; $display("FAIL wr_awvalid got=%b want=1", awvalid_m0); end
        n_vec++; if (arvalid_m0 !== 1'b0) begin n_bad++; $display("FAIL wr_arvalid got=%b want=0", arvalid_m0); end
        n_vec++; if (awaddr_m0 !== 32'h0000_2000) begin n_bad++; $display("FAIL wr_awaddr got=%h want=00002000", awaddr_m0); end
        n_vec++; if (awlen_m0 !== 8'd3) begin n_bad++; $display("FAIL wr_awlen got=%h want=03", awlen_m0); end
        n_vec++; if ({awburst_m0, awsize_m0, awid_m0} !== {2'b01, 3'b100, 8'h5A})
            begin n_bad++; $display("FAIL wr_awattr got=%b/%b/%h want=01/100/5a", awburst_m0, awsize_m0, awid_m0); end
        @(posedge clk); #1 awready_m0 = 1;
        @(posedge clk); #1 awready_m0 = 0; wready_m0 = 1;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c % 3 == 0 && pushed < 4) begin
                wd_vld = 1; wd_data = rand128(); wd_strb = STRB'($urandom());
                exp_q.push_back('{wd_data, wd_strb, (pushed == 3)});
                pushed++;
            end else begin
                wd_vld = 0;
            end
            @(negedge clk);
            n_vec++; if (wvalid_m0 !== wd_vld) begin n_bad++; $display("FAIL wr_wvalid_pass got=%b want=%b", wvalid_m0, wd_vld); end
            if (wvalid_m0 && wready_m0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++; if (wdata_m0 !== e.d) begin n_bad++; $display("FAIL wr_wdata beat%0d got=%h want=%h", beats, wdata_m0, e.d); end
                n_vec++; if (wstrb_m0 !== e.s) begin n_bad++; $display("FAIL wr_wstrb beat%0d got=%h want=%h", beats, wstrb_m0, e.s); end
                n_vec++; if (wlast_m0 !== e.l) begin n_bad++; $display("FAIL wr_wlast beat%0d got=%b want=%b", beats, wlast_m0, e.l); end
                n_vec++; if (wd_rdy !== 1'b1) begin n_bad++; $display("FAIL wr_wd_rdy got=%b want=1", wd_rdy); end
                beats++;
            end
        end
        n_vec++; if (beats != 4) begin n_bad++; $display("FAIL wr_beat_count got=%0d want=4", beats); end
        @(posedge clk); #1 wd_vld = 0;
        @(negedge clk);
        n_vec++; if (bready_m0 !== 1'b1) begin n_bad++; $display("FAIL wr_bready got=%b want=1", bready_m0); end
        n_vec++; if (wr_done !== 1'b0) begin n_bad++; $display("FAIL wr_done_early got=%b want=0", wr_done); end
        @(posedge clk); #1 bvalid_m0 = 1; bresp_m0 = 2'b00;
        @(negedge clk);
        n_vec++; if (wr_done !== 1'b1) begin n_bad++; $display("FAIL wr_done_pulse got=%b want=1", wr_done); end
        @(posedge clk); #1 bvalid_m0 = 0;
        @(negedge clk);
        n_vec++; if (wr_done !== 1'b0) begin n_bad++; $display("FAIL wr_done_after got=%b want=0", wr_done); end
        n_vec++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL wr_idle got=%b want=1", req_rdy); end
        n_vec++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL wr_err got=%b want=0", err_sticky); end
        wready_m0 = 0;
        exp_q.delete();
    endtask

    task automatic test_read_stall();
        beat_t e;
        int beats, stall;
        bit presented;
        beats = 0; stall = 0; presented = 0;
        issue_req(1'b0, 32'h0000_3000, 8'd3);
        @(posedge clk); #1 arready_m0 = 1;
        @(posedge clk); #1 arready_m0 = 0;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (!presented) begin
                rdata_m0 = rand128(); rvalid_m0 = 1; rlast_m0 = (beats == 3); rresp_m0 = 0;
                exp_q.push_back('{rdata_m0, '0, (beats == 3)});
                presented = 1;
            end
            rsp_rdy = !(beats == 2 && stall < 5);
            @(negedge clk);
            if (!rsp_rdy) begin
                stall++;
                n_vec++; if (rready_m0 !== 1'b0) begin n_bad++; $display("FAIL rds_rready_stall got=%b want=0", rready_m0); end
                n_vec++; if (rsp_data !== exp_q[0].d) begin n_bad++; $display("FAIL rds_data_held got=%h want=%h", rsp_data, exp_q[0].d); end
            end else if (rsp_vld && rready_m0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++; if (rsp_data !== e.d) begin n_bad++; $display("FAIL rds_data beat%0d got=%h want=%h", beats, rsp_data, e.d); end
                n_vec++; if (rsp_last !== e.l) begin n_bad++; $display("FAIL rds_last beat%0d got=%b want=%b", beats, rsp_last, e.l); end
                beats++; presented = 0;
            end else begin
                n_vec++; n_bad++;
                $display("FAIL rds_beat got vld=%b rready=%b want 1/1", rsp_vld, rready_m0);
            end
        end
        n_vec++; if (beats != 4 || stall != 5) begin n_bad++; $display("FAIL rds_counts got beats=%0d stalls=%0d want 4/5", beats, stall); end
        @(posedge clk); #1 rvalid_m0 = 0; rlast_m0 = 0; rsp_rdy = 0;
        @(negedge clk);
        n_vec++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL rds_idle got=%b want=1", req_rdy); end
        n_vec++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL rds_err got=%b want=0", err_sticky); end
        exp_q.delete();
    endtask

    task automatic test_bresp_err();
        issue_req(1'b1, 32'h0000_0040, 8'd0);
        @(posedge clk); #1 awready_m0 = 1;
        @(posedge clk); #1 awready_m0 = 0; wready_m0 = 1;
        wd_vld = 1; wd_data = rand128(); wd_strb = '1;
        @(negedge clk);
        n_vec++; if (wlast_m0 !== 1'b1) begin n_bad++; $display("FAIL be_wlast got=%b want=1", wlast_m0); end
        @(posedge clk); #1 wd_vld = 0; wready_m0 = 0; bvalid_m0 = 1; bresp_m0 = 2'b10;
        @(negedge clk);
        n_vec++; if (wr_done !== 1'b1) begin n_bad++; $display("FAIL be_wr_done got=%b want=1", wr_done); end
        @(posedge clk); #1 bvalid_m0 = 0; bresp_m0 = 2'b00;
        @(negedge clk);
        n_vec++; if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL be_err_sticky got=%b want=1", err_sticky); end
        n_vec++; if (err_code !== 2'b01) begin n_bad++; $display("FAIL be_err_code got=%b want=01", err_code); end
        n_vec++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL be_idle got=%b want=1", req_rdy); end
    endtask

    task automatic test_rlast_err();
        issue_req(1'b0, 32'h0000_0800, 8'd1);
        @(posedge clk); #1 arready_m0 = 1;
        @(posedge clk); #1 arready_m0 = 0;
        rsp_rdy = 1; rvalid_m0 = 1; rdata_m0 = rand128(); rlast_m0 = 1; rresp_m0 = 0;
        @(negedge clk);
        n_vec++; if (rsp_last !== 1'b0) begin n_bad++; $display("FAIL rl_last0 got=%b want=0", rsp_last); end
        @(posedge clk); #1 rdata_m0 = rand128(); rlast_m0 = 1;
        @(negedge clk);
        n_vec++; if (rsp_last !== 1'b1) begin n_bad++; $display("FAIL rl_last1 got=%b want=1", rsp_last); end
        @(posedge clk); #1 rvalid_m0 = 0; rlast_m0 = 0; rsp_rdy = 0;
        @(negedge clk);
        n_vec++; if (err_code !== 2'b10) begin n_bad++; $display("FAIL rl_err_code got=%b want=10", err_code); end
        n_vec++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL rl_idle got=%b want=1", req_rdy); end
    endtask

    task automatic test_timeout_and_reset();
        bit seen;
        seen = 0;
        issue_req(1'b0, 32'h0000_0500, 8'd3);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        n_vec++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL to_early got=%b want=0", err_sticky); end
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = err_sticky;
        end
        n_vec++; if (!seen) begin n_bad++; $display("FAIL to_flag got=0 want=1 within 1100 cycles"); end
        n_vec++; if (err_code !== 2'b11) begin n_bad++; $display("FAIL to_err_code got=%b want=11", err_code); end
        n_vec++; if (arvalid_m0 !== 1'b1) begin n_bad++; $display("FAIL to_still_waiting got=%b want=1", arvalid_m0); end
        @(posedge clk); #1 arready_m0 = 1;
        @(posedge clk); #1 arready_m0 = 0;
        rsp_rdy = 1; rvalid_m0 = 1; rdata_m0 = rand128(); rlast_m0 = 0; rresp_m0 = 0;
        @(negedge clk);
        n_vec++; if (rsp_vld !== 1'b1) begin n_bad++; $display("FAIL mr_in_r got=%b want=1", rsp_vld); end
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0; rvalid_m0 = 0;
        @(negedge clk);
        n_vec++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL mr_idle got=%b want=1", req_rdy); end
        n_vec++; if (rready_m0 !== 1'b0) begin n_bad++; $display("FAIL mr_rready got=%b want=0", rready_m0); end
        n_vec++; if (arvalid_m0 !== 1'b0) begin n_bad++; $display("FAIL mr_arvalid got=%b want=0", arvalid_m0); end
        n_vec++; if ({err_sticky, err_code} !== 3'b000) begin n_bad++; $display("FAIL mr_err got=%b%b want=000", err_sticky, err_code); end
        rsp_rdy = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_read_single();
        test_write_gaps();
        test_read_stall();
        test_bresp_err();
        apply_reset(2);
        test_rlast_err();
        apply_reset(2);
        test_timeout_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
